// File: rtl/adder_pkg.sv
// Shared widths, FSM state encoding and output beat payload for the adder stream framer.
package adder_pkg;

    localparam int unsigned DATAW  = 128;
    localparam int unsigned LENW   = 8;
    localparam int unsigned FRAMEW = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    typedef struct packed {
        logic             last;
        logic [DATAW-1:0] data;
    } beat_t;

endpackage

// File: rtl/adder_sync_fifo.sv
// Synchronous operand FIFO with registered pointers; the extra pointer bit separates full from empty.
module adder_sync_fifo #(
    parameter int unsigned DATAW      = 128,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [DATAW-1:0] wdata_i,
    input  logic             pop_i,
    output logic [DATAW-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DATAW-1:0] mem_q [FIFO_DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/adder_stream_framer.sv
// Buffers producer operands and emits them as AXI-Stream beats, marking tlast at the end of
// each frame of frame_len operands (one adder accumulation).
module adder_stream_framer
    import adder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATAW-1:0]  in_data,
    output logic              in_ready,
    input  logic [LENW-1:0]   frame_len,
    output logic              axis_adder_interface_tvalid,
    output logic              axis_adder_interface_tlast,
    output logic [DATAW-1:0]  axis_adder_interface_tdata,
    input  logic              axis_adder_interface_tready,
    output logic [FRAMEW-1:0] frames_sent,
    output logic              busy
);

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATAW-1:0]  fifo_rdata;

    state_e            state_q, state_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [LENW-1:0]   beat_cnt_q, beat_cnt_d;
    beat_t             beat_q, beat_d;
    logic              tvalid_q, tvalid_d;
    logic [FRAMEW-1:0] frames_q, frames_d;

    logic              take;
    logic              frame_end;
    logic              load;
    logic [LENW-1:0]   len_new;

    adder_sync_fifo #(
        .DATAW      (DATAW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdata_i (in_data),
        .pop_i   (load),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign take      = tvalid_q && axis_adder_interface_tready;
    assign frame_end = take && beat_q.last;
    assign load      = !fifo_empty && (!tvalid_q || axis_adder_interface_tready);
    assign len_new   = (frame_len == '0) ? LENW'(1) : frame_len;

    // beat_cnt counts beats already loaded in the current frame.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        beat_d     = beat_q;
        tvalid_d   = tvalid_q;
        frames_d   = frames_q;

        if (take) begin
            tvalid_d    = 1'b0;
            beat_d.last = 1'b0;
        end

        if (frame_end) begin
            frames_d   = frames_q + FRAMEW'(1);
            state_d    = IDLE;
            beat_cnt_d = '0;
        end

        // A frame starts from IDLE or right as the previous frame's last beat leaves.
        if (load) begin
            tvalid_d    = 1'b1;
            beat_d.data = fifo_rdata;
            if ((state_q == IDLE) || frame_end) begin
                len_d       = len_new;
                beat_cnt_d  = LENW'(1);
                beat_d.last = (len_new == LENW'(1));
                state_d     = STREAM;
            end else begin
                beat_d.last = (beat_cnt_q == (len_q - LENW'(1)));
                beat_cnt_d  = beat_cnt_q + LENW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= LENW'(1);
            beat_cnt_q <= '0;
            beat_q     <= '0;
            tvalid_q   <= 1'b0;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            beat_q     <= beat_d;
            tvalid_q   <= tvalid_d;
            frames_q   <= frames_d;
        end
    end

    assign in_ready                    = !fifo_full;
    assign axis_adder_interface_tvalid = tvalid_q;
    assign axis_adder_interface_tlast  = beat_q.last;
    assign axis_adder_interface_tdata  = beat_q.data;
    assign frames_sent                 = frames_q;
    assign busy                        = (state_q == STREAM) || !fifo_empty || tvalid_q;

endmodule

// File: tb/tb_adder_stream_framer.sv
// Directed and randomized bench for adder_stream_framer against a queue-based frame model.
module tb_adder_stream_framer;
    import adder_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATAW-1:0]  in_data;
    logic              in_ready;
    logic [LENW-1:0]   frame_len;
    logic              tvalid;
    logic              tlast;
    logic [DATAW-1:0]  tdata;
    logic              tready;
    logic [FRAMEW-1:0] frames_sent;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted operands in order, position within frame, completed frames.
    logic [DATAW-1:0] exp_q [$];
    logic [DATAW-1:0] exp_beat;
    int               pos        = 0;
    int               cur_len    = 1;
    int               frames_exp = 0;
    bit               stall_prev = 1'b0;
    logic [DATAW-1:0] prev_data;
    logic             prev_last;
    int               acc;

    always #5 clk = ~clk;

    adder_stream_framer dut (
        .clk                         (clk),
        .rst                         (rst),
        .in_valid                    (in_valid),
        .in_data                     (in_data),
        .in_ready                    (in_ready),
        .frame_len                   (frame_len),
        .axis_adder_interface_tvalid (tvalid),
        .axis_adder_interface_tlast  (tlast),
        .axis_adder_interface_tdata  (tdata),
        .axis_adder_interface_tready (tready),
        .frames_sent                 (frames_sent),
        .busy                        (busy)
    );

    task automatic chk(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor at negedge: inputs are stable here and are what the next posedge consumes.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pos        = 0;
            frames_exp = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", DATAW'(tvalid), DATAW'(1));
                chk("hold_data", tdata, prev_data);
                chk("hold_last", DATAW'(tlast), DATAW'(prev_last));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", DATAW'(tvalid), DATAW'(0));
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (pos == 0) cur_len = (frame_len == '0) ? 1 : int'(frame_len);
                    chk("beat_data", tdata, exp_beat);
                    chk("beat_last", DATAW'(tlast), DATAW'(pos == cur_len - 1));
                    chk("frames_at_beat", DATAW'(frames_sent), DATAW'(frames_exp));
                    if (pos == cur_len - 1) begin
                        pos = 0;
                        frames_exp++;
                    end else begin
                        pos++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            stall_prev = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        tready   = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = rnd();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int n = 0;
        tready = 1'b1;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            if (toggle) tready = ~tready;
            n++;
        end
        tready = 1'b1;
        chk("drain_left", DATAW'(exp_q.size()), DATAW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        frame_len = LENW'(17);
        tready    = 1'b0;
        #1;
        chk("rst_tvalid", DATAW'(tvalid), DATAW'(0));
        chk("rst_tlast", DATAW'(tlast), DATAW'(0));
        chk("rst_tdata", tdata, DATAW'(0));
        chk("rst_in_ready", DATAW'(in_ready), DATAW'(1));
        chk("rst_frames", DATAW'(frames_sent), DATAW'(0));
        chk("rst_busy", DATAW'(busy), DATAW'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: 17-beat frame, contiguous, first tvalid one cycle after first accept
        tready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            in_valid = 1'b1;
            in_data  = DATAW'(i);
            @(posedge clk); #1;
            if (i == 1) chk("lat_pre_valid", DATAW'(tvalid), DATAW'(0));
            if (i == 2) begin
                chk("lat_valid", DATAW'(tvalid), DATAW'(1));
                chk("lat_data", tdata, DATAW'(1));
            end
        end
        in_valid = 1'b0;
        drain(1'b0);
        chk("t1_frames", DATAW'(frames_sent), DATAW'(1));
        chk("t1_busy", DATAW'(busy), DATAW'(0));

        // 2: frame_len 4, tready toggling
        do_reset();
        frame_len = LENW'(4);
        for (int i = 0; i < 8; i++) begin
            tready   = (i % 2 == 0);
            in_valid = 1'b1;
            in_data  = rnd();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain(1'b1);
        chk("t2_frames", DATAW'(frames_sent), DATAW'(2));
        chk("t2_busy", DATAW'(busy), DATAW'(0));

        // 3: fill under backpressure, then drain in order
        do_reset();
        frame_len = LENW'(8);
        tready    = 1'b0;
        acc       = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = rnd();
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("t3_accepted", DATAW'(acc), DATAW'(17));
        chk("t3_in_ready", DATAW'(in_ready), DATAW'(0));
        chk("t3_tvalid", DATAW'(tvalid), DATAW'(1));
        drain(1'b0);
        chk("t3_frames", DATAW'(frames_sent), DATAW'(2));
        chk("t3_busy_partial", DATAW'(busy), DATAW'(1));

        // 4: frame_len 0 behaves as single-beat frames
        do_reset();
        frame_len = '0;
        tready    = 1'b1;
        push_n(3);
        drain(1'b0);
        chk("t4_frames", DATAW'(frames_sent), DATAW'(3));
        chk("t4_busy", DATAW'(busy), DATAW'(0));

        // 5: reset mid-frame discards everything
        do_reset();
        frame_len = LENW'(5);
        tready    = 1'b1;
        push_n(3);
        drain(1'b0);
        chk("t5_frames_mid", DATAW'(frames_sent), DATAW'(0));
        chk("t5_busy_mid", DATAW'(busy), DATAW'(1));
        tready = 1'b0;
        push_n(2);
        @(posedge clk); #1;
        chk("t5_tvalid_pre", DATAW'(tvalid), DATAW'(1));
        rst = 1'b1;
        #1;
        chk("t5_rst_tvalid", DATAW'(tvalid), DATAW'(0));
        chk("t5_rst_tdata", tdata, DATAW'(0));
        chk("t5_rst_busy", DATAW'(busy), DATAW'(0));
        chk("t5_rst_in_ready", DATAW'(in_ready), DATAW'(1));
        chk("t5_rst_frames", DATAW'(frames_sent), DATAW'(0));
        @(negedge clk);
        @(posedge clk); #1;
        rst    = 1'b0;
        tready = 1'b1;
        push_n(5);
        drain(1'b0);
        chk("t5_frames", DATAW'(frames_sent), DATAW'(1));
        chk("t5_busy", DATAW'(busy), DATAW'(0));

        // 6: frame_len change mid-frame applies only to the next frame
        do_reset();
        frame_len = LENW'(3);
        tready    = 1'b1;
        push_n(1);
        drain(1'b0);
        frame_len = LENW'(2);
        push_n(2);
        drain(1'b0);
        chk("t6_frames_a", DATAW'(frames_sent), DATAW'(1));
        push_n(2);
        drain(1'b0);
        chk("t6_frames_b", DATAW'(frames_sent), DATAW'(2));
        chk("t6_busy", DATAW'(busy), DATAW'(0));

        // 7: random valid/ready traffic with a random fixed frame length
        do_reset();
        frame_len = LENW'($urandom_range(1, 6));
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rnd();
            tready   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain(1'b0);
        chk("t7_frames", DATAW'(frames_sent), DATAW'(frames_exp));
        chk("t7_busy", DATAW'(busy), DATAW'(pos != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
